// File: rtl/strobe_period_checker.sv
// ---------------------------------------------------------------------------
// strobe_period_checker
//
// Sits next to a divide-by-N strobe generator. It measures the interval
// between one-cycle strobes, declares lock after LOCK_CNT consecutive
// intervals of exactly DIV cycles, and then reports early or missing strobes
// while locked. Lock is lost after ERR_MAX consecutive bad intervals.
//
// Parameters:
//   DIV       expected strobe period in clk cycles (2..127)
//   LOCK_CNT  consecutive good intervals needed to lock (1..15)
//   ERR_MAX   consecutive bad intervals in LOCKED that drop lock (1..15)
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       asynchronous active-low reset
//   en        synchronous checker enable; low returns the FSM to IDLE
//   strb_in   strobe under test
//   locked    high while the FSM is in LOCKED
//   err       one-cycle pulse per bad interval detected in LOCKED
//   miss      one-cycle pulse per missing strobe (flywheel or ACQ timeout)
//   period_o  last measured interval in cycles
//
// Optional build macro:
//   STRB_EDGE_EN  strb_in goes through a registered rising-edge detector, so
//                 a held level counts once; all event outputs gain 1 cycle.
// ---------------------------------------------------------------------------
module strobe_period_checker #(
  parameter int unsigned DIV      = 3,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_MAX  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       strb_in,
  output logic       locked,
  output logic       err,
  output logic       miss,
  output logic [7:0] period_o
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACQ,
    LOCKED
  } state_t;

  localparam logic [7:0] C_DIV  = 8'(DIV);
  localparam logic [7:0] C_TMO  = 8'(2 * DIV);
  localparam logic [3:0] C_LOCK = 4'(LOCK_CNT);
  localparam logic [3:0] C_ERR  = 4'(ERR_MAX);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_good;
  logic [3:0] r_bad;
  logic       r_err;
  logic       r_miss;
  logic [7:0] r_period;
  logic       w_strb;

`ifdef STRB_EDGE_EN
  logic r_strb_d;
  logic r_strb_evt;

  // Registered edge pulse: one strobe event per rising edge of strb_in,
  // presented one cycle after the first high sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_strb_d   <= 1'b0;
      r_strb_evt <= 1'b0;
    end else begin
      r_strb_d   <= strb_in;
      r_strb_evt <= strb_in & ~r_strb_d;
    end
  end

  assign w_strb = r_strb_evt;
`else
  assign w_strb = strb_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_good   <= '0;
      r_bad    <= '0;
      r_err    <= 1'b0;
      r_miss   <= 1'b0;
      r_period <= '0;
    end else begin
      r_err  <= 1'b0;
      r_miss <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_good  <= '0;
        r_bad   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= SYNC;
          end

          SYNC: begin
            // First strobe only sets the phase; no interval is measured.
            if (w_strb) begin
              r_state <= ACQ;
              r_cnt   <= 8'd1;
              r_good  <= '0;
            end
          end

          ACQ: begin
            if (w_strb) begin
              r_period <= r_cnt;
              r_cnt    <= 8'd1;
              if (r_cnt == C_DIV) begin
                r_good <= r_good + 4'd1;
                if (r_good + 4'd1 == C_LOCK) begin
                  r_state <= LOCKED;
                  r_bad   <= '0;
                end
              end else begin
                r_good <= '0;
              end
            end else if (r_cnt >= C_TMO) begin
              // Strobe train vanished: resynchronise from scratch.
              r_miss  <= 1'b1;
              r_state <= SYNC;
              r_cnt   <= '0;
              r_good  <= '0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end

          LOCKED: begin
            if (w_strb) begin
              r_period <= r_cnt;
            end
            if (w_strb && (r_cnt == C_DIV)) begin
              r_bad <= '0;
              r_cnt <= 8'd1;
            end else if (w_strb || (r_cnt == C_DIV)) begin
              // Early strobe re-phases; a missing one flywheels to the
              // virtual strobe position. Both count as a bad interval.
              r_err  <= 1'b1;
              r_miss <= ~w_strb;
              r_cnt  <= 8'd1;
              if (r_bad + 4'd1 == C_ERR) begin
                r_state <= ACQ;
                r_good  <= '0;
                r_bad   <= '0;
              end else begin
                r_bad <= r_bad + 4'd1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign locked   = (r_state == LOCKED);
  assign err      = r_err;
  assign miss     = r_miss;
  assign period_o = r_period;

endmodule

// File: tb/tb_strobe_period_checker.sv
module tb_strobe_period_checker;

  localparam int DIV      = 3;
  localparam int LOCK_CNT = 4;
  localparam int ERR_MAX  = 2;
`ifdef STRB_EDGE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       en      = 1'b0;
  logic       strb_in = 1'b0;
  logic       locked;
  logic       err;
  logic       miss;
  logic [7:0] period_o;

  always #5 clk = ~clk;

  strobe_period_checker #(
    .DIV(DIV),
    .LOCK_CNT(LOCK_CNT),
    .ERR_MAX(ERR_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .strb_in(strb_in),
    .locked(locked),
    .err(err),
    .miss(miss),
    .period_o(period_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks absolute cycle timestamps of the last strobe
  // (real or virtual) and derives intervals by subtraction.
  localparam int M_IDLE = 0, M_SYNC = 1, M_ACQ = 2, M_LOCK = 3;
  int m_st = M_IDLE, m_now = 0, m_last = 0, m_good = 0, m_bad = 0, m_per = 0;
  bit m_err = 0, m_miss = 0, m_p1 = 0, m_p2 = 0;

  task automatic model_reset();
    m_st = M_IDLE; m_now = 0; m_last = 0; m_good = 0; m_bad = 0; m_per = 0;
    m_err = 0; m_miss = 0; m_p1 = 0; m_p2 = 0;
  endtask

  task automatic model_step(input bit e, input bit s);
    bit ev;
    int d;
`ifdef STRB_EDGE_EN
    ev = m_p1 & ~m_p2;
`else
    ev = s;
`endif
    m_p2 = m_p1;
    m_p1 = s;
    m_now++;
    d = m_now - m_last;
    m_err = 0;
    m_miss = 0;
    if (!e) begin
      m_st = M_IDLE; m_good = 0; m_bad = 0;
    end else begin
      case (m_st)
        M_IDLE: m_st = M_SYNC;
        M_SYNC: if (ev) begin m_st = M_ACQ; m_last = m_now; m_good = 0; end
        M_ACQ: begin
          if (ev) begin
            m_per = (d > 255) ? 255 : d;
            m_last = m_now;
            if (d == DIV) begin
              m_good++;
              if (m_good == LOCK_CNT) begin m_st = M_LOCK; m_bad = 0; end
            end else m_good = 0;
          end else if (d >= 2 * DIV) begin
            m_miss = 1; m_st = M_SYNC;
          end
        end
        default: begin
          if (ev) m_per = d;
          if (ev && d == DIV) begin
            m_last = m_now; m_bad = 0;
          end else if (ev || d == DIV) begin
            m_err = 1; m_miss = !ev; m_last = m_now; m_bad++;
            if (m_bad == ERR_MAX) begin m_st = M_ACQ; m_good = 0; end
          end
        end
      endcase
    end
  endtask

  always @(posedge clk) if (rst) model_step(en, strb_in);
  always @(negedge rst) model_reset();

  bit mon_on = 0;
  always @(negedge clk) begin
    if (mon_on) begin
      check("model_locked", locked, (m_st == M_LOCK) ? 1 : 0);
      check("model_err", err, m_err);
      check("model_miss", miss, m_miss);
      check("model_period", period_o, m_per);
    end
  end

  // One cycle: inputs driven after negedge, outputs sampled 1 after posedge.
  task automatic drive(input bit e, input bit s);
    @(negedge clk);
    en = e;
    strb_in = s;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       en;
    bit       s;
    bit       l;
    bit       e;
    bit       m;
    int       p;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit e_i, input bit s_i, input bit l, input bit e, input bit m, input int p);
    vec_t v;
    v.en = e_i; v.s = s_i; v.l = l; v.e = e; v.m = m; v.p = p;
    tbl.push_back(v);
  endtask

  task automatic zeros(input int n, input bit l, input int p);
    for (int i = 0; i < n; i++) add(1, 0, l, 0, 0, p);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_locked", locked, 0);
    check("reset_err", err, 0);
    check("reset_miss", miss, 0);
    check("reset_period", period_o, 0);
    mon_on = 1;
    @(negedge clk);
    rst = 1'b1;

`ifndef STRB_EDGE_EN
    // Acquire and lock
    add(1, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0); zeros(2, 0, 0);
    add(1, 1, 0, 0, 0, 3); zeros(2, 0, 3); add(1, 1, 0, 0, 0, 3); zeros(2, 0, 3);
    add(1, 1, 0, 0, 0, 3); zeros(2, 0, 3); add(1, 1, 1, 0, 0, 3);
    // Omitted strobe: flywheel err+miss, next good strobe clears bad
    zeros(2, 1, 3); add(1, 0, 1, 1, 1, 3); zeros(2, 1, 3); add(1, 1, 1, 0, 0, 3);
    // Two early strobes: lock lost
    add(1, 0, 1, 0, 0, 3); add(1, 1, 1, 1, 0, 2); add(1, 0, 1, 0, 0, 2); add(1, 1, 0, 1, 0, 2);
    // Relock after four good intervals
    zeros(2, 0, 2); add(1, 1, 0, 0, 0, 3); zeros(2, 0, 3); add(1, 1, 0, 0, 0, 3);
    zeros(2, 0, 3); add(1, 1, 0, 0, 0, 3); zeros(2, 0, 3); add(1, 1, 1, 0, 0, 3);
    // Disable, resync, then ACQ timeout after 6 quiet cycles
    add(0, 0, 0, 0, 0, 3); add(1, 0, 0, 0, 0, 3); add(1, 1, 0, 0, 0, 3);
    zeros(5, 0, 3); add(1, 0, 0, 0, 1, 3); add(1, 0, 0, 0, 0, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].s);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].l);
      check($sformatf("tbl%0d_err", i), err, tbl[i].e);
      check($sformatf("tbl%0d_miss", i), miss, tbl[i].m);
      check($sformatf("tbl%0d_period", i), period_o, tbl[i].p);
    end
`else
    // Held levels: high 2, low 1, so one rising edge every 3 cycles
    drive(0, 0);
    drive(1, 0);
    for (int k = 0; k < 8; k++) begin
      drive(1, 1); drive(1, 1); drive(1, 0);
    end
    check("held_locked", locked, 1);
    check("held_period", period_o, 3);
`endif

    // Lock, then asynchronous reset between edges
    drive(0, 0);
    drive(1, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1, 1); drive(1, 0); drive(1, 0);
    end
    check("prerst_locked", locked, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_err", err, 0);
    check("async_miss", miss, 0);
    check("async_period", period_o, 0);
    @(negedge clk);
    rst = 1'b1;

    // After release, lock appears exactly after the 5th strobe is seen
    drive(1, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1);
      repeat (LAT) drive(1, 0);
      check($sformatf("relock_strobe%0d", k + 1), locked, (k == 4) ? 1 : 0);
      repeat (2 - LAT) drive(1, 0);
    end
    check("relock_period", period_o, 3);

    // Randomised intervals, occasional disables
    for (int seg = 0; seg < 300; seg++) begin
      int r, g, h;
      r = $urandom_range(0, 99);
      g = (r < 70) ? DIV : (r < 80) ? DIV - 1 : (r < 87) ? 1 : (r < 94) ? DIV + 1 : 2 * DIV + 1;
`ifdef STRB_EDGE_EN
      h = (g > 1) ? $urandom_range(1, g - 1) : 1;
`else
      h = 1;
`endif
      for (int i = 0; i < g; i++) begin
        drive(($urandom_range(0, 199) != 0), (i < h));
      end
    end

    @(negedge clk);
    mon_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/strobe_period_checker.md
Name: strobe_period_checker

Overview:
Receiving end of the divide-by-N strobe generators in this codebase. It watches a one-cycle strobe train, such as the y output of a divide-by-3 FSM, and measures the interval between strobes. It declares lock after enough consecutive correct intervals, then flags early or missing strobes while locked. It is used as a self-check and sync monitor next to clock-divider/enable generators.

Parameters:
DIV, 3, expected strobe period in clk cycles (2..127).
LOCK_CNT, 4, consecutive good intervals required to enter LOCKED (1..15).
ERR_MAX, 2, consecutive bad intervals in LOCKED that cause loss of lock (1..15).

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  reset. Asynchronous and active-low: asserted when 0.
en  in  1  checker enable. Sampled synchronously.
strb_in  in  1  strobe under test. Each sampled high cycle is one strobe event (see optional feature).
locked  out  1  high while the FSM is in LOCKED (Moore output).
err  out  1  one-cycle pulse per bad interval detected in LOCKED.
miss  out  1  one-cycle pulse per missing strobe (flywheel in LOCKED, timeout in ACQ).
period_o  out  8  last measured interval in cycles, saturating at 255.

Behaviour:
- Reset (rst=0), applied asynchronously:
  - state=IDLE; all outputs 0; period_o=0.
  - Interval counter cnt=0, good count=0, bad count=0.
- cnt semantics: cnt=1 in the cycle after a strobe and increments each cycle. It saturates at 2*DIV in ACQ and SYNC.
- A strobe at cnt==DIV is a good interval. period_o is loaded with cnt (saturated) on every strobe in ACQ and LOCKED.
- FSM states: IDLE, SYNC, ACQ, LOCKED.
  - IDLE: en=1 -> SYNC.
  - SYNC: waits for the first strobe. On strobe -> ACQ with cnt<=1 and good<=0. No interval is measured.
  - ACQ, on strobe:
    - cnt==DIV: good++. If good reaches LOCK_CNT -> LOCKED with bad<=0.
    - cnt!=DIV: good<=0 and stay in ACQ.
    - In both cases cnt<=1.
  - ACQ timeout: cnt reaches 2*DIV with no strobe -> miss pulse, go to SYNC.
  - LOCKED:
    - Strobe at cnt==DIV: bad<=0.
    - Strobe at cnt<DIV (early): err pulse, bad++, cnt<=1 (re-phase).
    - Missing strobe (cnt==DIV and strb_in=0): err and miss pulse, bad++, cnt<=1 (flywheel to the virtual strobe).
    - When bad reaches ERR_MAX -> ACQ with good<=0. locked drops in the next cycle.
  - Any state with en=0 -> IDLE at the next edge. In that cycle cnt, good and bad clear and err and miss are forced 0. period_o holds its value.
- Output timing:
  - err, miss and period_o are registered. Each is valid in the cycle after the clk edge that sampled the event.
  - err and miss are high for exactly one cycle per event.
  - locked follows the state register directly.
- Simultaneous events: a strobe in the flywheel cycle (cnt==DIV) is good; there is never both an error and a good interval on one edge.
- Reset mid-operation: immediate return to reset values. Relock requires the full SYNC -> ACQ -> LOCKED sequence.

Optional Feature:
STRB_EDGE_EN
- Defined: strb_in passes through an internal rising-edge detector, registered with reset value 0. A level held high for several cycles counts as one strobe at its first high cycle, which adds 1 cycle of latency to all event outputs.
- Undefined: every sampled high cycle of strb_in is a strobe event, with no extra latency.

Test Plan:
1. Defaults, en=1, strobe every 3 cycles from t=10 -> locked=1 in the cycle after the edge sampling the 5th strobe. period_o=3; err and miss never high.
2. Locked, then one strobe omitted -> err=1 and miss=1 for one cycle at the expected strobe time. locked stays 1; the next correct strobe clears bad.
3. Locked, then two consecutive strobes at interval 2 -> two single-cycle err pulses with period_o=2. locked=0 in the cycle after the second; relock after 4 good intervals.
4. In ACQ, strb_in held 0 for 6 cycles -> one miss pulse, state SYNC, locked=0. A new strobe train locks normally.
5. rst=0 asynchronously mid-LOCKED -> locked, err, miss and period_o go to 0 without a clock edge. After release, behaviour is identical to scenario 1.
6. en=0 while locked -> locked=0 one cycle later. With STRB_EDGE_EN defined, strb_in high for 3 cycles every 3 cycles of low, i.e. period 6 with DIV=6, locks with period_o=6.
